mult_seq_mnbit: RTL

Parametrised sequential shift-add multiplier: M-bit multiplicand × N-bit multiplier → (M+N)-bit product, one multiplier bit retired per clock.
Runtime-selectable unsigned or two's-complement signed mode; valid/ready handshake on both input and output.
Successor to the combinational array multiplier: trades N adder rows for one (M+1)-bit adder/subtractor plus a small FSM, for area-constrained datapaths.

---
 rtl/mult_seq_mnbit_pkg.sv | 17 +
 rtl/mult_seq_mnbit_addsub.sv | 28 ++
 rtl/mult_seq_mnbit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mult_seq_mnbit_pkg.sv
// mult_pkg: shared types and helpers for the sequential shift-add multiplier.
//   mult_state_t : control FSM states (IDLE, RUN, DONE)
//   cnt_width()  : width of the iteration counter for an N-bit multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Counter must be able to hold 0..N.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mult_seq_mnbit_addsub.sv
// addsub_nbit: W-bit ripple-carry adder/subtractor.
//   a, b : operands
//   sub  : 0 -> sum = a + b, 1 -> sum = a - b (b inverted, carry-in = 1)
//   sum  : W-bit result, carry-out discarded (modulo 2^W)
module addsub_nbit #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  logic [W-1:0] b_eff;
  logic [W-1:0] carry;

  assign b_eff    = b ^ {W{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i] = a[i] ^ b_eff[i] ^ carry[i];
    // The carry out of the top bit is not needed, so the chain stops at W-1.
    if (i < W - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
  end

endmodule

// File: rtl/mult_seq_mnbit.sv
// mult_seq_mnbit: M x N sequential shift-add multiplier, one multiplier bit
// retired per clock, unsigned or two's-complement selectable per operation.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, is_signed sampled together)
//   out_valid / out_ready: result handshake, prod held until accepted
//   prod                 : (M+N)-bit product
// Build option: define MULT_ZERO_BYPASS_EN to finish zero-operand jobs after
// a single step instead of N.
module mult_seq_mnbit
  import mult_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M+N-1:0] prod
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mult_state_t   state;
  logic [M:0]    mcand;
  logic          mode;
  logic [CW-1:0] cnt;
  logic [M+N:0]  p;        // {acc[M:0], multiplier[N-1:0]}

  logic [M:0]    acc;
  logic [M:0]    sum;
  logic [M:0]    acc_new;
  logic          sub;
  logic          fill;
  logic [M+N:0]  p_next;
  logic          bypass;

  assign acc = p[M+N:N];

  // The multiplier's sign bit carries weight -2^(N-1) in signed mode, so the
  // last partial product is subtracted instead of added.
  assign sub = mode && (cnt == LAST);

  addsub_nbit #(.W(M + 1)) u_addsub (
    .a   (acc),
    .b   (mcand),
    .sub (sub),
    .sum (sum)
  );

  assign acc_new = p[0] ? sum : acc;
  assign fill    = mode & acc_new[M];
  assign p_next  = {fill, acc_new, p[N-1:1]};

`ifdef MULT_ZERO_BYPASS_EN
  assign bypass = (a == '0) || (b == '0);
`else
  assign bypass = 1'b0;
`endif

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would make the order of statements matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mode      <= 1'b0;
      cnt       <= '0;
      p         <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      prod      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= is_signed ? {a[M-1], a} : {1'b0, a};
            mode     <= is_signed;
            in_ready <= 1'b0;
            state    <= RUN;
            if (bypass) begin
              // A zero product: one step with an all-zero register yields 0,
              // so jump straight to the final iteration.
              p   <= '0;
              cnt <= LAST;
            end else begin
              p   <= {{(M+1){1'b0}}, b};
              cnt <= '0;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end

        RUN: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            prod      <= p_next[M+N-1:0];
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
